// File: rtl/key_calc_if.sv
// Key-pad strobe/code inputs and display-stage outputs of the key calculator.
interface key_calc_if;
  logic       key_stb;
  logic [3:0] key_code;
  logic [9:0] ans;
  logic       error;
  logic [1:0] state;

  modport master (output key_stb, key_code, input ans, error, state);
  modport slave  (input key_stb, key_code, output ans, error, state);
endinterface

// File: rtl/key_calc_core.sv
// Key-driven signed calculator: synchronised key events, sign/magnitude operand
// entry, ADD/AND/OR/XOR on 10-bit two's complement, error state on overflow.
module key_calc_core #(
   parameter int unsigned LOCKOUT_CYCLES = 16
) (
   input logic        clk,
   input logic        rst_n,
   key_calc_if.slave  bus
);

   localparam int unsigned LW = (LOCKOUT_CYCLES < 1) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

   typedef enum logic [1:0] {ENT_A = 2'd0, ENT_B = 2'd1, SHOW_RES = 2'd2, ERR = 2'd3} state_t;
   typedef enum logic [1:0] {OP_ADD = 2'd0, OP_AND = 2'd1, OP_OR = 2'd2, OP_XOR = 2'd3} op_t;

   logic          r_sync1, r_sync2, r_hist;
   logic [LW-1:0] r_lock;
   state_t        r_state, w_state_nxt;
   op_t           r_op, w_op_nxt;
   logic          r_a_sign, r_b_sign, w_a_sign_nxt, w_b_sign_nxt;
   logic [9:0]    r_a_mag, r_b_mag, w_a_mag_nxt, w_b_mag_nxt;
   logic [1:0]    r_a_cnt, r_b_cnt, w_a_cnt_nxt, w_b_cnt_nxt;
   logic [9:0]    r_ans, w_ans_nxt, w_show_nxt;
   logic          r_err;

   logic          w_evt;
   logic [3:0]    w_code;
   logic          w_is_digit, w_is_op;
   logic [9:0]    w_cur_mag;
   logic [13:0]   w_dig_val;
   logic [9:0]    w_a_tc, w_b_tc, w_res, w_r_mag;
   logic [10:0]   w_sum;
   logic          w_ovf;

   function automatic logic [9:0] to_tc(input logic s, input logic [9:0] m);
      return s ? (~m + 10'd1) : m;
   endfunction

   // Edges arriving while the lockout counter runs are lost; r_hist still
   // tracks the level so a key held past the lockout cannot fire again.
   assign w_evt      = r_sync2 & ~r_hist & (r_lock == '0);
   assign w_code     = bus.key_code;
   assign w_is_digit = (w_code < 4'd10);
   assign w_is_op    = (w_code >= 4'd11) && (w_code <= 4'd14);
   assign w_cur_mag  = (r_state == ENT_B) ? r_b_mag : r_a_mag;
   assign w_dig_val  = 14'(w_cur_mag) * 14'd10 + 14'(w_code);

   assign w_a_tc  = to_tc(r_a_sign, r_a_mag);
   assign w_b_tc  = to_tc(r_b_sign, r_b_mag);
   assign w_sum   = {w_a_tc[9], w_a_tc} + {w_b_tc[9], w_b_tc};
   assign w_ovf   = w_sum[10] ^ w_sum[9];
   assign w_r_mag = r_ans[9] ? (~r_ans + 10'd1) : r_ans;

   always_comb begin
      w_res = w_sum[9:0];
      case (r_op)
         OP_AND:  w_res = w_a_tc & w_b_tc;
         OP_OR:   w_res = w_a_tc | w_b_tc;
         OP_XOR:  w_res = w_a_tc ^ w_b_tc;
         default: w_res = w_sum[9:0];
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_op_nxt     = r_op;
      w_a_sign_nxt = r_a_sign;
      w_a_mag_nxt  = r_a_mag;
      w_a_cnt_nxt  = r_a_cnt;
      w_b_sign_nxt = r_b_sign;
      w_b_mag_nxt  = r_b_mag;
      w_b_cnt_nxt  = r_b_cnt;
      w_show_nxt   = r_ans;
      if (w_evt) begin
         case (r_state)
            ENT_A, ENT_B: begin
               if (w_is_digit) begin
                  if (((r_state == ENT_A) ? r_a_cnt : r_b_cnt) < 2'd3) begin
                     if (w_dig_val > 14'd511) begin
                        w_state_nxt = ERR;
                     end else if (r_state == ENT_A) begin
                        w_a_mag_nxt = w_dig_val[9:0];
                        w_a_cnt_nxt = r_a_cnt + 2'd1;
                     end else begin
                        w_b_mag_nxt = w_dig_val[9:0];
                        w_b_cnt_nxt = r_b_cnt + 2'd1;
                     end
                  end
               end else if (w_code == 4'd10) begin
                  if (r_state == ENT_A) w_a_sign_nxt = ~r_a_sign;
                  else                  w_b_sign_nxt = ~r_b_sign;
               end else if (w_is_op) begin
                  w_op_nxt = op_t'(w_code - 4'd11);
                  if (r_state == ENT_A) begin
                     w_b_sign_nxt = 1'b0;
                     w_b_mag_nxt  = '0;
                     w_b_cnt_nxt  = '0;
                     w_state_nxt  = ENT_B;
                  end
               end else if (r_state == ENT_B) begin
                  if ((r_op == OP_ADD) && w_ovf) begin
                     w_state_nxt = ERR;
                  end else begin
                     w_show_nxt  = w_res;
                     w_state_nxt = SHOW_RES;
                  end
               end
            end
            SHOW_RES: begin
               if (w_is_digit || w_is_op) begin
                  w_b_sign_nxt = 1'b0;
                  w_b_mag_nxt  = '0;
                  w_b_cnt_nxt  = '0;
               end
               if (w_is_digit) begin
                  w_a_sign_nxt = 1'b0;
                  w_a_mag_nxt  = 10'(w_code);
                  w_a_cnt_nxt  = 2'd1;
                  w_state_nxt  = ENT_A;
               end else if (w_is_op) begin
                  w_a_sign_nxt = r_ans[9];
                  w_a_mag_nxt  = w_r_mag;
                  w_a_cnt_nxt  = '0;
                  w_op_nxt     = op_t'(w_code - 4'd11);
                  w_state_nxt  = ENT_B;
               end
            end
            default: begin
               if (w_code == 4'd15) begin
                  w_a_sign_nxt = 1'b0;
                  w_a_mag_nxt  = '0;
                  w_a_cnt_nxt  = '0;
                  w_b_sign_nxt = 1'b0;
                  w_b_mag_nxt  = '0;
                  w_b_cnt_nxt  = '0;
                  w_state_nxt  = ENT_A;
               end
            end
         endcase
      end
      case (w_state_nxt)
         ENT_A:    w_ans_nxt = to_tc(w_a_sign_nxt, w_a_mag_nxt);
         ENT_B:    w_ans_nxt = to_tc(w_b_sign_nxt, w_b_mag_nxt);
         SHOW_RES: w_ans_nxt = w_show_nxt;
         default:  w_ans_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_hist   <= 1'b0;
         r_lock   <= '0;
         r_state  <= ENT_A;
         r_op     <= OP_ADD;
         r_a_sign <= 1'b0;
         r_a_mag  <= '0;
         r_a_cnt  <= '0;
         r_b_sign <= 1'b0;
         r_b_mag  <= '0;
         r_b_cnt  <= '0;
         r_ans    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_sync1  <= bus.key_stb;
         r_sync2  <= r_sync1;
         r_hist   <= r_sync2;
         if (w_evt)             r_lock <= LW'(LOCKOUT_CYCLES);
         else if (r_lock != '0) r_lock <= r_lock - 1'b1;
         r_state  <= w_state_nxt;
         r_op     <= w_op_nxt;
         r_a_sign <= w_a_sign_nxt;
         r_a_mag  <= w_a_mag_nxt;
         r_a_cnt  <= w_a_cnt_nxt;
         r_b_sign <= w_b_sign_nxt;
         r_b_mag  <= w_b_mag_nxt;
         r_b_cnt  <= w_b_cnt_nxt;
         r_ans    <= w_ans_nxt;
         r_err    <= (w_state_nxt == ERR);
      end
   end

   assign bus.ans   = r_ans;
   assign bus.error = r_err;
   assign bus.state = r_state;

endmodule

// File: tb/tb_key_calc_core.sv
// Directed key-sequence bench for key_calc_core with an expected-result queue.
module tb_key_calc_core;

   typedef struct {
      string      tag;
      logic [9:0] ans;
      logic       err;
      logic [1:0] st;
   } exp_t;

   localparam logic [3:0] K_SIGN = 4'd10, K_ADD = 4'd11, K_AND = 4'd12,
                          K_OR = 4'd13, K_XOR = 4'd14, K_EQ = 4'd15;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   exp_t sb[$];

   key_calc_if bus ();

   key_calc_core #(.LOCKOUT_CYCLES(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [9:0] a, input logic e, input logic [1:0] s);
      exp_t x;
      x.tag = tag; x.ans = a; x.err = e; x.st = s;
      sb.push_back(x);
   endtask

   task automatic check_out();
      exp_t x;
      n_assert++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL sb_empty: observed %0d expected %0d", 0, 1);
      end
      if (sb.size() > 0) begin
         x = sb.pop_front();
         cmp({x.tag, ".ans"}, bus.ans, x.ans);
         cmp({x.tag, ".err"}, 10'(bus.error), 10'(x.err));
         cmp({x.tag, ".state"}, 10'(bus.state), 10'(x.st));
      end
   endtask

   task automatic press(input logic [3:0] code, input string tag,
                        input logic [9:0] a, input logic e, input logic [1:0] s);
      expect_out(tag, a, e, s);
      @(negedge clk);
      bus.key_stb  = 1'b1;
      bus.key_code = code;
      repeat (3) @(posedge clk);
      #1;
      check_out();
      bus.key_stb = 1'b0;
      repeat (20) @(posedge clk);
   endtask

   task automatic pulse_reset(input string tag);
      expect_out(tag, 10'd0, 1'b0, 2'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_out();
      #2;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      n_assert     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      bus.key_stb  = 1'b0;
      bus.key_code = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      expect_out("reset", 10'd0, 1'b0, 2'd0);
      check_out();
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      press(4'd1, "pre1", 10'd1, 1'b0, 2'd0);
      press(4'd2, "pre12", 10'd12, 1'b0, 2'd0);
      pulse_reset("async_reset");

      press(4'd1, "a1", 10'd1, 1'b0, 2'd0);
      press(4'd2, "a12", 10'd12, 1'b0, 2'd0);
      press(4'd3, "a123", 10'd123, 1'b0, 2'd0);
      press(K_ADD, "add_op", 10'd0, 1'b0, 2'd1);
      press(4'd4, "b4", 10'd4, 1'b0, 2'd1);
      press(4'd5, "b45", 10'd45, 1'b0, 2'd1);
      press(K_EQ, "sum168", 10'd168, 1'b0, 2'd2);
      press(K_ADD, "chain_add", 10'd0, 1'b0, 2'd1);
      press(4'd2, "chain_b2", 10'd2, 1'b0, 2'd1);
      press(K_EQ, "sum170", 10'd170, 1'b0, 2'd2);
      press(K_EQ, "show_eq_ign", 10'd170, 1'b0, 2'd2);

      press(4'd3, "ov_a3", 10'd3, 1'b0, 2'd0);
      press(4'd0, "ov_a30", 10'd30, 1'b0, 2'd0);
      press(4'd0, "ov_a300", 10'd300, 1'b0, 2'd0);
      press(K_ADD, "ov_add", 10'd0, 1'b0, 2'd1);
      press(4'd3, "ov_b3", 10'd3, 1'b0, 2'd1);
      press(4'd0, "ov_b30", 10'd30, 1'b0, 2'd1);
      press(4'd0, "ov_b300", 10'd300, 1'b0, 2'd1);
      press(K_EQ, "ov_err", 10'd0, 1'b1, 2'd3);
      press(4'd7, "err_dig_ign", 10'd0, 1'b1, 2'd3);
      press(K_SIGN, "err_sign_ign", 10'd0, 1'b1, 2'd3);
      press(K_EQ, "err_clear", 10'd0, 1'b0, 2'd0);

      press(4'd5, "x_a5", 10'd5, 1'b0, 2'd0);
      press(K_SIGN, "x_neg5", 10'h3FB, 1'b0, 2'd0);
      press(K_XOR, "x_op", 10'd0, 1'b0, 2'd1);
      press(4'd3, "x_b3", 10'd3, 1'b0, 2'd1);
      press(K_EQ, "xor_res", 10'h3F8, 1'b0, 2'd2);
      press(4'd5, "n_a5", 10'd5, 1'b0, 2'd0);
      press(K_SIGN, "n_neg5", 10'h3FB, 1'b0, 2'd0);
      press(K_AND, "n_op", 10'd0, 1'b0, 2'd1);
      press(4'd3, "n_b3", 10'd3, 1'b0, 2'd1);
      press(K_EQ, "and_res", 10'd3, 1'b0, 2'd2);
      press(K_OR, "res_to_a", 10'd0, 1'b0, 2'd1);
      press(K_EQ, "or_res_b0", 10'd3, 1'b0, 2'd2);

      press(4'd1, "d1", 10'd1, 1'b0, 2'd0);
      press(4'd2, "d12", 10'd12, 1'b0, 2'd0);
      press(4'd3, "d123", 10'd123, 1'b0, 2'd0);
      press(4'd4, "d4th_ign", 10'd123, 1'b0, 2'd0);
      press(K_SIGN, "d_neg0_chk", 10'h385, 1'b0, 2'd0);
      pulse_reset("reset2");
      press(4'd5, "e5", 10'd5, 1'b0, 2'd0);
      press(4'd1, "e51", 10'd51, 1'b0, 2'd0);
      press(4'd2, "e512_err", 10'd0, 1'b1, 2'd3);
      press(K_EQ, "e_clear", 10'd0, 1'b0, 2'd0);
      press(K_SIGN, "neg_zero", 10'd0, 1'b0, 2'd0);
      press(K_SIGN, "pos_zero", 10'd0, 1'b0, 2'd0);

      expect_out("hold7", 10'd7, 1'b0, 2'd0);
      @(negedge clk);
      bus.key_stb  = 1'b1;
      bus.key_code = 4'd7;
      repeat (100) @(posedge clk);
      #1;
      check_out();
      bus.key_stb = 1'b0;
      repeat (20) @(posedge clk);

      press(K_ADD, "lk_add", 10'd0, 1'b0, 2'd1);
      expect_out("lk_b1", 10'd1, 1'b0, 2'd1);
      @(negedge clk);
      bus.key_stb  = 1'b1;
      bus.key_code = 4'd1;
      repeat (3) @(posedge clk);
      #1;
      check_out();
      bus.key_stb = 1'b0;
      repeat (2) @(posedge clk);
      bus.key_stb  = 1'b1;
      bus.key_code = 4'd2;
      repeat (3) @(posedge clk);
      bus.key_stb = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      expect_out("lk_drop", 10'd1, 1'b0, 2'd1);
      check_out();
      press(4'd3, "lk_after", 10'd13, 1'b0, 2'd1);
      press(K_OR, "op_replace", 10'd13, 1'b0, 2'd1);
      press(K_EQ, "or_res", 10'd15, 1'b0, 2'd2);

      n_assert++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_leftover: observed %0d expected %0d", sb.size(), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/key_calc_core.md
KEY_CALC_CORE -- requirements
Module: key_calc_core

Interface
REQ-001 SHALL have parameter LOCKOUT_CYCLES, default 16: clocks after an accepted key during which further key_stb rising edges are ignored.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port key_stb, input, 1: asynchronous key-press strobe (level, high while key held).
REQ-005 SHALL have port key_code, input, 4: 0-9 digit, 10 SIGN, 11 ADD, 12 AND, 13 OR, 14 XOR, 15 EQ; stable while key_stb high.
REQ-006 SHALL have port ans, output, 10: two's-complement value for the display stage, registered.
REQ-007 SHALL have port error, output, 1: blanks the display stage when high, registered.
REQ-008 SHALL have port state, output, 2: 0 ENT_A, 1 ENT_B, 2 SHOW_RES, 3 ERR, registered.

Function
REQ-009 SHALL pass key_stb through a 2-flop synchroniser plus a history flop; a key event is a low-to-high transition at the synchroniser output.
REQ-010 SHALL sample key_code in the event cycle, and state/ans/error SHALL reflect the event after the next rising edge (3 edges after key_stb first sampled high).
REQ-011 SHALL produce one event per press regardless of hold time; after each event, new edges SHALL be ignored for LOCKOUT_CYCLES clocks (counter reloads on event, counts to 0).
REQ-012 SHALL hold operand A and operand B as sign flag plus 10-bit unsigned magnitude, and a latched op (ADD/AND/OR/XOR).
REQ-013 Digit key in ENT_A/ENT_B: mag = mag*10 + digit if fewer than 3 digits entered; 4th and later digits ignored.
REQ-014 Digit entry making mag > 511 SHALL go to ERR.
REQ-015 SIGN key in ENT_A/ENT_B SHALL toggle the current operand's sign flag; ignored in SHOW_RES and ERR.
REQ-016 In ENT_A, ans SHALL equal A as two's complement (sign ? -mag : mag); in ENT_B, ans SHALL equal B likewise; -0 shows as 0.
REQ-017 Op key in ENT_A SHALL latch op, clear B (mag 0, positive, 0 digits) and go to ENT_B.
REQ-018 Op key in ENT_B SHALL replace the latched op with no other change.
REQ-019 EQ in ENT_A SHALL be ignored.
REQ-020 EQ in ENT_B SHALL compute the result and go to SHOW_RES with ans = result.
REQ-021 ADD SHALL use an 11-bit signed sum; a result outside -512..511 SHALL go to ERR.
REQ-022 AND/OR/XOR SHALL be bitwise on the 10-bit two's-complement operands and never overflow.
REQ-023 In SHOW_RES, a digit key SHALL clear A and B, start A with that digit and go to ENT_A.
REQ-024 In SHOW_RES, an op key SHALL load A from the result (sign/magnitude), latch the op, clear B and go to ENT_B.
REQ-025 In SHOW_RES, EQ SHALL be ignored.
REQ-026 In ERR, error SHALL be 1 and ans SHALL hold 0.
REQ-027 In ERR, only EQ SHALL clear all operands and go to ENT_A with error = 0; all other keys SHALL be ignored.
REQ-028 Key events during lockout SHALL be dropped silently, with no queueing.

Reset
REQ-029 rst_n low SHALL immediately force ans = 0, error = 0, state = ENT_A, A = B = 0 positive, digit counts 0, op = ADD, lockout counter 0, synchroniser flops 0.
REQ-030 Reset asserted mid-entry or mid-lockout SHALL discard all pending data; the first key after release SHALL be accepted once synchronised.

Verification
REQ-031 Reset check: pulse rst_n low mid-entry -> ans = 0, error = 0, state = 0 asynchronously.
REQ-032 Addition: keys 1,2,3,ADD,4,5,EQ -> ans = 168, state = 2; then ADD,2,EQ -> ans = 170.
REQ-033 Overflow recovery: 3,0,0,ADD,3,0,0,EQ -> error = 1, state = 3; digit 7 is ignored; EQ -> error = 0, ans = 0, state = 0.
REQ-034 Bitwise with sign: 5,SIGN,XOR,3,EQ -> ans = 10'h3F8 (-8); 5,SIGN,AND,3,EQ -> ans = 3.
REQ-035 Digit entry limits: 1,2,3,4 -> ans = 123; after reset, 5,1,2 -> error = 1.
REQ-036 Press handling: key_stb held 100 cycles with code 7 -> ans = 7, not 77; a second press inside LOCKOUT_CYCLES is dropped, and one after it is accepted.
